// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation modes and sequencer states.
// Also holds a helper that tells which modes the multi-step sequencer may repeat.
package usr_pkg;

    typedef enum logic [2:0] {
        USR_HOLD  = 3'b000,
        USR_LOAD  = 3'b001,
        USR_SHL   = 3'b010,
        USR_SHR   = 3'b011,
        USR_ROL   = 3'b100,
        USR_ROR   = 3'b101,
        USR_ASR   = 3'b110,
        USR_CLEAR = 3'b111
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Shift/rotate modes are the only ones worth repeating
    function automatic logic is_shift(input mode_e m);
        return (m inside {USR_SHL, USR_SHR, USR_ROL, USR_ROR, USR_ASR});
    endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational next-value function of the shift register for one operation.
// Ports: q (current word), mode, sin_l/sin_r (serial fills), din (load data), nxt (result).
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_e            mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = q;
        unique case (mode)
            USR_HOLD:  nxt = q;
            USR_LOAD:  nxt = din;
            USR_SHL:   nxt = {q[WIDTH-2:0], sin_r};
            USR_SHR:   nxt = {sin_l, q[WIDTH-1:1]};
            USR_ROL:   nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            USR_ROR:   nxt = {q[0], q[WIDTH-1:1]};
            USR_ASR:   nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            USR_CLEAR: nxt = '0;
            default:   nxt = q;
        endcase
    end

endmodule

// File: rtl/usr_shift_reg.sv
// Universal shift register with single-step ops and a start/busy/done multi-step sequencer.
// Ports: clk, rst (sync, active-high), en, mode, Din, sin_l, sin_r, start, amt -> Q, Qbar,
// sout_l, sout_r, busy, done, and par (even parity of Q) only when USR_PARITY_EN is defined.
module usr_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] Din,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNTW-1:0]  amt,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
`ifdef USR_PARITY_EN
    ,
    output logic             par
`endif
);

    localparam logic [CNTW-1:0] AMT_MAX = CNTW'(WIDTH);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;

    mode_e            mode_in;
    mode_e            step_mode;
    logic [WIDTH-1:0] step_q;

    assign mode_in = mode_e'(mode);

    // While running, the latched mode drives the shared step function
    assign step_mode = (state_q == RUN) ? mode_q : mode_in;

    usr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q     (q_q),
        .mode  (step_mode),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .din   (Din),
        .nxt   (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= USR_HOLD;
            cnt_q   <= '0;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_shift(mode_in) && (amt != '0)) begin
                        state_d = RUN;
                        mode_d  = mode_in;
                        cnt_d   = (amt > AMT_MAX) ? AMT_MAX : amt;
                    end else begin
                        // Zero-length shift is a no-op that still completes
                        if (!is_shift(mode_in)) begin
                            q_d = step_q;
                        end
                        done_d = 1'b1;
                    end
                end else if (en) begin
                    q_d = step_q;
                end
            end
            RUN: begin
                q_d   = step_q;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Q      = q_q;
    assign Qbar   = ~q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign busy   = (state_q == RUN);
    assign done   = done_q;

`ifdef USR_PARITY_EN
    assign par = ^q_q;
`endif

endmodule

// File: tb/tb_usr_shift_reg.sv
// Self-checking bench for usr_shift_reg: directed scenarios plus randomized traffic
// compared each cycle against an arithmetic reference model.
module tb_usr_shift_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] Din = 8'd0;
    logic       sin_l = 1'b0;
    logic       sin_r = 1'b0;
    logic       start = 1'b0;
    logic [3:0] amt = 4'd0;
    logic [7:0] Q;
    logic [7:0] Qbar;
    logic       sout_l;
    logic       sout_r;
    logic       busy;
    logic       done;
`ifdef USR_PARITY_EN
    logic       par;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int unsigned m_q = 0;
    int          m_left = 0;
    int          m_mode = 0;
    bit          m_done = 0;

    usr_shift_reg dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .Din    (Din),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .start  (start),
        .amt    (amt),
        .Q      (Q),
        .Qbar   (Qbar),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
`ifdef USR_PARITY_EN
        ,
        .par    (par)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned apply(input int unsigned q, input int m,
                                          input bit sl, input bit sr,
                                          input int unsigned d);
        case (m)
            0: return q;
            1: return d;
            2: return ((q * 2) + sr) % 256;
            3: return (q / 2) + (sl ? 128 : 0);
            4: return ((q * 2) % 256) + (q / 128);
            5: return (q / 2) + ((q % 2) * 128);
            6: return (q / 2) + ((q >= 128) ? 128 : 0);
            default: return 0;
        endcase
    endfunction

    function automatic bit shift_mode(input int m);
        return (m >= 2) && (m <= 6);
    endfunction

    // Advance the model from the inputs about to be sampled
    task automatic model_edge();
        if (rst) begin
            m_q = 0;
            m_left = 0;
            m_done = 0;
        end else if (m_left > 0) begin
            m_q = apply(m_q, m_mode, sin_l, sin_r, Din);
            m_left--;
            m_done = (m_left == 0);
        end else begin
            m_done = 0;
            if (start) begin
                if (shift_mode(mode) && amt != 0) begin
                    m_left = (amt > 8) ? 8 : int'(amt);
                    m_mode = mode;
                end else begin
                    if (!shift_mode(mode))
                        m_q = apply(m_q, mode, sin_l, sin_r, Din);
                    m_done = 1;
                end
            end else if (en) begin
                m_q = apply(m_q, mode, sin_l, sin_r, Din);
            end
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit s, input int m,
                       input int unsigned d, input int a, input bit sl, input bit sr);
        rst = r;
        en = e;
        start = s;
        mode = 3'(m);
        Din = 8'(d);
        amt = 4'(a);
        sin_l = sl;
        sin_r = sr;
        model_edge();
        @(posedge clk);
        #1;
        chk("q", Q, m_q);
        chk("qbar", Qbar, (~m_q) & 8'hFF);
        chk("busy", busy, (m_left > 0) ? 1 : 0);
        chk("done", done, m_done);
        chk("sout_l", sout_l, m_q / 128);
        chk("sout_r", sout_r, m_q % 2);
`ifdef USR_PARITY_EN
        chk("par", par, $countones(m_q) % 2);
`endif
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input int unsigned d);
        cyc(0, 1, 0, 1, d, 0, 0, 0);
    endtask

    int busy_cnt;

    initial begin
        @(posedge clk);
        #1;

        cyc(1, 1, 0, 1, 8'hFF, 0, 0, 0);
        cyc(1, 1, 0, 1, 8'hFF, 0, 0, 0);
        chk("rst_q", Q, 0);
        chk("rst_qbar", Qbar, 8'hFF);

        load(8'hA5);
        chk("load", Q, 8'hA5);
        cyc(0, 1, 0, 4, 0, 0, 0, 0);
        chk("rol", Q, 8'h4B);
        cyc(0, 1, 0, 5, 0, 0, 0, 0);
        chk("ror", Q, 8'hA5);
        cyc(0, 1, 0, 6, 0, 0, 0, 0);
        chk("asr", Q, 8'hD2);
        cyc(0, 1, 0, 7, 0, 0, 0, 0);
        chk("clear", Q, 0);

        load(8'h81);
        cyc(0, 0, 1, 2, 0, 3, 0, 1);
        chk("shl_start_q", Q, 8'h81);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("shl_1", Q, 8'h03);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("shl_2", Q, 8'h07);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("shl_3", Q, 8'h0F);
        chk("shl_done", done, 1);
        idle();
        chk("shl_done_pulse", done, 0);

        load(8'h5A);
        cyc(0, 0, 1, 3, 0, 0, 1, 1);
        chk("amt0_q", Q, 8'h5A);
        chk("amt0_done", done, 1);
        cyc(0, 1, 1, 1, 8'h33, 0, 0, 0);
        chk("start_load_q", Q, 8'h33);
        chk("start_load_done", done, 1);

        load(8'h01);
        cyc(0, 0, 1, 5, 0, 5, 0, 0);
        cyc(0, 1, 1, 1, 8'hEE, 3, 0, 0);
        chk("ror_ignore", Q, 8'h80);
        cyc(1, 1, 1, 1, 8'hEE, 3, 0, 0);
        chk("abort_q", Q, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        idle();

        load(8'h3C);
        cyc(0, 0, 1, 4, 0, 12, 0, 0);
        busy_cnt = 0;
        for (int i = 0; i < 12 && busy; i++) begin
            busy_cnt++;
            cyc(0, 1, 1, 7, 0, 0, 0, 0);
        end
        chk("clamp_busy", busy_cnt, 8);
        chk("clamp_q", Q, 8'h3C);
        chk("clamp_done", done, 1);

`ifdef USR_PARITY_EN
        load(8'h07);
        chk("par_07", par, 1);
        load(8'h03);
        chk("par_03", par, 0);
`endif

        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 40) == 0), $urandom_range(0, 1),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 7),
                $urandom_range(0, 255), $urandom_range(0, 15),
                $urandom_range(0, 1), $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
